misr_sig_analyzer: RTL and testbench

//  Response-side BIST block: compresses the stream of result words that comes back from the systolic array

---
 rtl/misr_sig_analyzer.sv | 156 +++++++++++++++
 tb/tb_misr_sig_analyzer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/misr_sig_analyzer.sv
// Response-side BIST signature analyzer: folds returned array words into a
// MISR (or captures the raw word), then compares the final signature against a
// golden value under a bit mask and reports pass/fail with a one-cycle done.

package misr_sig_analyzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

module misr_sig_analyzer
    import misr_sig_analyzer_pkg::*;
#(
    parameter int unsigned               DATA_WIDTH = 49,
    parameter logic [DATA_WIDTH-1:0]     POLY       = 49'h200,
    parameter int unsigned               CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_mode,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [DATA_WIDTH-1:0] i_seed,
    input  logic                  i_vld,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic [DATA_WIDTH-1:0] i_golden,
    input  logic [DATA_WIDTH-1:0] i_mask,
    output logic                  o_busy,
    output logic [DATA_WIDTH-1:0] o_signature,
    output logic [CNT_WIDTH-1:0]  o_count,
    output logic                  o_done,
    output logic                  o_pass
);

    state_e                r_state;
    state_e                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_sig;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_pass;
    logic                  r_busy;
    logic                  r_done;

    logic [DATA_WIDTH-1:0] w_sig_nxt;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic                  w_pass_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;

    logic [DATA_WIDTH-1:0] w_feedback;
    logic [DATA_WIDTH-1:0] w_compress;
    logic [DATA_WIDTH-1:0] w_absorb;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic                  w_match;

    // Galois MISR step, capture alternative, saturating count and masked compare
    always_comb begin
        w_feedback = r_sig[DATA_WIDTH-1] ? POLY : '0;
        w_compress = {r_sig[DATA_WIDTH-2:0], 1'b0} ^ w_feedback ^ i_data;
        w_absorb   = i_mode ? w_compress : i_data;
        w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_WIDTH'(1);
        w_match    = ((r_sig ^ i_golden) & i_mask) == '0;
    end

    // Next-state and datapath update; abort outranks start, start outranks last
    always_comb begin
        w_state_nxt = r_state;
        w_sig_nxt   = r_sig;
        w_cnt_nxt   = r_cnt;
        w_pass_nxt  = r_pass;

        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_state_nxt = ST_RUN;
                    w_sig_nxt   = i_seed;
                    w_cnt_nxt   = '0;
                    w_pass_nxt  = 1'b0;
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_start) begin
                    // restart drops whatever word arrives this cycle
                    w_sig_nxt = i_seed;
                    w_cnt_nxt = '0;
                end else begin
                    if (i_vld) begin
                        w_sig_nxt = w_absorb;
                        w_cnt_nxt = w_cnt_inc;
                    end
                    if (i_last) begin
                        w_state_nxt = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_pass_nxt  = w_match;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = state_e'(2'bxx);
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_CHECK);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Signature, counter and status registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sig  <= '0;
            r_cnt  <= '0;
            r_pass <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_sig  <= w_sig_nxt;
            r_cnt  <= w_cnt_nxt;
            r_pass <= w_pass_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign o_busy      = r_busy;
    assign o_signature = r_sig;
    assign o_count     = r_cnt;
    assign o_done      = r_done;
    assign o_pass      = r_pass;

endmodule

// File: tb/tb_misr_sig_analyzer.sv
// Directed bench for misr_sig_analyzer at DATA_WIDTH=8, POLY=8'h1D, CNT_WIDTH=4.
module tb_misr_sig_analyzer;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic       start;
    logic       abort;
    logic [7:0] seed;
    logic       vld;
    logic [7:0] data;
    logic       last;
    logic [7:0] golden;
    logic [7:0] mask;
    logic       busy;
    logic [7:0] signature;
    logic [3:0] count;
    logic       done;
    logic       pass;

    int n_checks;
    int n_errors;

    misr_sig_analyzer #(
        .DATA_WIDTH (8),
        .POLY       (8'h1D),
        .CNT_WIDTH  (4)
    ) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_mode      (mode),
        .i_start     (start),
        .i_abort     (abort),
        .i_seed      (seed),
        .i_vld       (vld),
        .i_data      (data),
        .i_last      (last),
        .i_golden    (golden),
        .i_mask      (mask),
        .o_busy      (busy),
        .o_signature (signature),
        .o_count     (count),
        .o_done      (done),
        .o_pass      (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock; outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] s, input logic m);
        seed  = s;
        mode  = m;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        vld  = 1'b1;
        data = d;
        step();
        vld  = 1'b0;
    endtask

    // last -> CHECK -> DONE (done two edges after last is sampled) -> IDLE
    task automatic finish_run(input string tag, input logic [7:0] g, input logic [7:0] mk,
                              input logic exp_pass);
        golden = g;
        mask   = mk;
        last   = 1'b1;
        step();
        last   = 1'b0;
        chk({tag, "_check_done"}, 64'(done), 64'(0));
        chk({tag, "_check_busy"}, 64'(busy), 64'(1));
        step();
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_pass"}, 64'(pass), 64'(exp_pass));
        step();
        chk({tag, "_done_drop"}, 64'(done), 64'(0));
        chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int saw_done;
        n_checks = 0;
        n_errors = 0;
        rst_n  = 1'b0;
        mode   = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        seed   = 8'h00;
        vld    = 1'b0;
        data   = 8'h00;
        last   = 1'b0;
        golden = 8'h00;
        mask   = 8'hFF;

        #12;
        chk("rst_sig",   64'(signature), 64'(0));
        chk("rst_count", 64'(count),     64'(0));
        chk("rst_busy",  64'(busy),      64'(0));
        chk("rst_done",  64'(done),      64'(0));
        chk("rst_pass",  64'(pass),      64'(0));
        step();
        rst_n = 1'b1;
        step();

        // 1. compress stream 01,80,00 -> 01,82,19
        start_run(8'h00, 1'b1);
        chk("t1_busy", 64'(busy), 64'(1));
        chk("t1_seed", 64'(signature), 64'(8'h00));
        push(8'h01);
        chk("t1_sig0", 64'(signature), 64'(8'h01));
        push(8'h80);
        chk("t1_sig1", 64'(signature), 64'(8'h82));
        push(8'h00);
        chk("t1_sig2", 64'(signature), 64'(8'h19));
        chk("t1_count", 64'(count), 64'(3));
        finish_run("t1", 8'h19, 8'hFF, 1'b1);

        // 2. wrong golden fails; masking the differing bit passes
        start_run(8'h00, 1'b1);
        chk("t2_pass_clr", 64'(pass), 64'(0));
        push(8'h01); push(8'h80); push(8'h00);
        finish_run("t2a", 8'h18, 8'hFF, 1'b0);
        start_run(8'h00, 1'b1);
        push(8'h01); push(8'h80); push(8'h00);
        finish_run("t2b", 8'h18, 8'hFE, 1'b1);

        // 3. capture mode keeps the last raw word
        start_run(8'h00, 1'b0);
        push(8'hA5); push(8'h3C);
        chk("t3_sig", 64'(signature), 64'(8'h3C));
        chk("t3_count", 64'(count), 64'(2));
        finish_run("t3", 8'h3C, 8'hFF, 1'b1);

        // 4a. 20 words saturate the 4-bit counter
        start_run(8'h00, 1'b0);
        for (int i = 0; i < 20; i++) push(8'(i));
        chk("t4_count_sat", 64'(count), 64'(4'hF));
        chk("t4_sig", 64'(signature), 64'(8'h13));
        finish_run("t4", 8'h13, 8'hFF, 1'b1);

        // 4b. last together with vld absorbs the word first
        start_run(8'h00, 1'b1);
        push(8'h01); push(8'h80);
        golden = 8'h19;
        mask   = 8'hFF;
        vld    = 1'b1;
        data   = 8'h00;
        last   = 1'b1;
        step();
        vld    = 1'b0;
        last   = 1'b0;
        chk("t4b_sig", 64'(signature), 64'(8'h19));
        chk("t4b_count", 64'(count), 64'(3));
        step();
        chk("t4b_done", 64'(done), 64'(1));
        chk("t4b_pass", 64'(pass), 64'(1));
        step();

        // 5a. abort mid-RUN: idle, values kept, no done, pass cleared
        start_run(8'h00, 1'b1);
        push(8'h01); push(8'h80);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5a_busy", 64'(busy), 64'(0));
        chk("t5a_sig", 64'(signature), 64'(8'h82));
        chk("t5a_count", 64'(count), 64'(2));
        saw_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) saw_done = 1;
            step();
        end
        chk("t5a_no_done", 64'(saw_done), 64'(0));
        chk("t5a_pass", 64'(pass), 64'(0));

        // 5b. abort in CHECK: no done, pass stays 0
        start_run(8'h00, 1'b1);
        push(8'h01);
        golden = 8'h01;
        last   = 1'b1;
        step();
        last   = 1'b0;
        abort  = 1'b1;
        step();
        abort  = 1'b0;
        chk("t5b_done", 64'(done), 64'(0));
        chk("t5b_busy", 64'(busy), 64'(0));
        step();
        chk("t5b_pass", 64'(pass), 64'(0));
        chk("t5b_done2", 64'(done), 64'(0));

        // 5c. restart mid-RUN reloads seed and drops that cycle's word
        start_run(8'h00, 1'b1);
        push(8'h01); push(8'h80);
        seed  = 8'h55;
        start = 1'b1;
        vld   = 1'b1;
        data  = 8'hFF;
        step();
        start = 1'b0;
        vld   = 1'b0;
        chk("t5c_sig", 64'(signature), 64'(8'h55));
        chk("t5c_count", 64'(count), 64'(0));
        chk("t5c_busy", 64'(busy), 64'(1));
        push(8'h01);
        chk("t5c_sig1", 64'(signature), 64'(8'hAB));
        finish_run("t5c", 8'hAB, 8'hFF, 1'b1);

        // 5d. start during CHECK is ignored
        start_run(8'h00, 1'b1);
        push(8'h01); push(8'h80); push(8'h00);
        golden = 8'h19;
        mask   = 8'hFF;
        last   = 1'b1;
        step();
        last   = 1'b0;
        seed   = 8'h77;
        start  = 1'b1;
        step();
        start  = 1'b0;
        chk("t5d_done", 64'(done), 64'(1));
        chk("t5d_pass", 64'(pass), 64'(1));
        chk("t5d_sig", 64'(signature), 64'(8'h19));
        step();
        chk("t5d_idle", 64'(busy), 64'(0));

        // 6. async reset between edges clears everything at once
        start_run(8'h00, 1'b1);
        push(8'h01); push(8'h80);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_sig", 64'(signature), 64'(0));
        chk("t6_count", 64'(count), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_done", 64'(done), 64'(0));
        step();
        chk("t6_hold_done", 64'(done), 64'(0));
        rst_n = 1'b1;
        step();

        // zero-length run compares the seed; all-zero mask always passes
        start_run(8'hAA, 1'b1);
        chk("t6_new_seed", 64'(signature), 64'(8'hAA));
        finish_run("zl", 8'hAA, 8'hFF, 1'b1);
        chk("zl_count", 64'(count), 64'(0));
        start_run(8'hAA, 1'b1);
        finish_run("m0", 8'h00, 8'h00, 1'b1);
        start_run(8'hAA, 1'b1);
        finish_run("zl_bad", 8'h00, 8'hFF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
